// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//  - OP_* encodings for the in_op port
//  - stage_payload_t: data, shift amount, opcode and fill bit that travel
//    together through every pipeline stage
//  - bit_reverse: reverses the low 'width' bits of a vector (used for SLL)
// Payload fields are sized for the widest supported operand (XLEN_MAX); narrower
// instances use the low bits only.
package shifter_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned SHW_MAX  = 6;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef struct packed {
        logic [XLEN_MAX-1:0] data;
        logic [SHW_MAX-1:0]  shamt;
        logic [1:0]          op;
        logic                fill;
    } stage_payload_t;

    // Reverse bits [width-1:0]; bits above width come back as zero.
    function automatic logic [XLEN_MAX-1:0] bit_reverse(input logic [XLEN_MAX-1:0] x,
                                                         input int unsigned         width);
        logic [XLEN_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < XLEN_MAX; i++) begin
            if (i < width) begin
                r[SHW_MAX'(i)] = x[SHW_MAX'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: mux levels FIRST_LVL ..
// FIRST_LVL+NUM_LVLS-1 followed by the stage's valid/payload register.
// Level k shifts right by 2**k when shamt[k] is set.
// The LAST stage also undoes the SLL bit reversal and registers the zero flag.
// Optional feature: SHIFTER_ROTATE_EN builds the ROR wrap path.
// Ports:
//  clk, rst_n  clock / asynchronous active-low reset
//  advance     1 = pipeline moves this cycle (no stall)
//  in_valid    upstream stage valid
//  in_pay      upstream payload
//  out_valid   registered valid
//  out_pay     registered payload
//  out_zero    registered result-is-zero flag (LAST stage only, else 0)
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned FIRST_LVL = 0,
    parameter int unsigned NUM_LVLS  = 1,
    parameter bit          LAST      = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           advance,
    input  logic           in_valid,
    input  stage_payload_t in_pay,
    output logic           out_valid,
    output stage_payload_t out_pay,
    output logic           out_zero
);

    logic [XLEN-1:0] d_c;
    logic            zero_c;
    stage_payload_t  nxt_c;

    // Mux levels owned by this stage, then output fix-up on the last stage.
    always_comb begin
        d_c = in_pay.data[XLEN-1:0];
        for (int unsigned k = FIRST_LVL; k < FIRST_LVL + NUM_LVLS; k++) begin
            if (((in_pay.shamt >> k) & SHW_MAX'(1)) != '0) begin
`ifdef SHIFTER_ROTATE_EN
                if (in_pay.op == OP_ROR) begin
                    d_c = (d_c >> (1 << k)) | (d_c << (XLEN - (1 << k)));
                end else begin
                    d_c = (d_c >> (1 << k)) | ({XLEN{in_pay.fill}} << (XLEN - (1 << k)));
                end
`else
                d_c = (d_c >> (1 << k)) | ({XLEN{in_pay.fill}} << (XLEN - (1 << k)));
`endif
            end
        end

        zero_c = (d_c == '0);
        nxt_c  = in_pay;
        if (LAST && (in_pay.op == OP_SLL)) begin
            nxt_c.data = bit_reverse(XLEN_MAX'(d_c), XLEN);
        end else begin
            nxt_c.data = XLEN_MAX'(d_c);
        end
    end

    // Bubbles advance the valid bit but leave the payload untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pay   <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pay <= nxt_c;
            end
        end
    end

    if (LAST) begin : g_zero
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_zero <= 1'b0;
            end else if (advance && in_valid) begin
                out_zero <= zero_c;
            end
        end
    end else begin : g_no_zero
        logic unused_zero_c;
        assign unused_zero_c = zero_c;
        assign out_zero      = 1'b0;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA(/ROR) barrel shifter with valid/ready on both sides.
// log2(XLEN) right-shift levels are split over PIPE_STAGES register stages;
// SLL is done by reversing the operand on entry and the result on exit.
// A single global stall (out_valid && !out_ready) freezes every stage.
// Optional feature: define SHIFTER_ROTATE_EN to build ROR for op 11; when
// undefined op 11 executes as SRL.
// Ports:
//  clk, rst_n           clock / asynchronous active-low reset
//  in_valid, in_ready   request handshake
//  in_data, in_shamt    operand and shift amount
//  in_op                00 SLL, 01 SRL, 10 SRA, 11 ROR
//  out_valid, out_ready result handshake
//  out_data, out_zero   result and result-is-zero flag
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned SHW         = $clog2(XLEN),
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    input  logic [1:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_zero
);

    localparam int unsigned LVLS_PER_STAGE = (SHW + PIPE_STAGES - 1) / PIPE_STAGES;

    if (XLEN > XLEN_MAX || XLEN < 8 || PIPE_STAGES < 1 || PIPE_STAGES > SHW) begin : g_param_check
        $error("pipelined_barrel_shifter: unsupported XLEN/PIPE_STAGES");
    end

    logic           stall_c;
    logic           vld [PIPE_STAGES+1];
    stage_payload_t pay [PIPE_STAGES+1];
    stage_payload_t entry_c;
    logic           unused_tail_c;

    assign stall_c  = out_valid && !out_ready;
    assign in_ready = !stall_c;

    // Entry payload: pre-reverse for SLL, capture the sign for SRA.
    always_comb begin
        entry_c       = '0;
        entry_c.data  = (in_op == OP_SLL) ? bit_reverse(XLEN_MAX'(in_data), XLEN)
                                          : XLEN_MAX'(in_data);
        entry_c.shamt = SHW_MAX'(in_shamt);
        entry_c.op    = in_op;
        entry_c.fill  = (in_op == OP_SRA) && in_data[XLEN-1];
    end

    assign vld[0] = in_valid;
    assign pay[0] = entry_c;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        // Earlier stages take a full share of levels; the last takes what is left.
        localparam int unsigned FIRST = (s * LVLS_PER_STAGE < SHW) ? s * LVLS_PER_STAGE : SHW;
        localparam int unsigned NUM   = (SHW - FIRST < LVLS_PER_STAGE) ? SHW - FIRST
                                                                       : LVLS_PER_STAGE;
        logic zero;

        shift_stage #(
            .XLEN      (XLEN),
            .FIRST_LVL (FIRST),
            .NUM_LVLS  (NUM),
            .LAST      (1'(s == PIPE_STAGES - 1))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (!stall_c),
            .in_valid  (vld[s]),
            .in_pay    (pay[s]),
            .out_valid (vld[s+1]),
            .out_pay   (pay[s+1]),
            .out_zero  (zero)
        );

        if (s == PIPE_STAGES - 1) begin : g_out
            assign out_zero = zero;
        end else begin : g_mid
            logic unused_zero;
            assign unused_zero = zero;
        end
    end

    assign out_valid     = vld[PIPE_STAGES];
    assign out_data      = pay[PIPE_STAGES].data[XLEN-1:0];
    assign unused_tail_c = ^{pay[PIPE_STAGES].shamt, pay[PIPE_STAGES].op, pay[PIPE_STAGES].fill};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (XLEN=64, PIPE_STAGES=2).
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_zero;

    pipelined_barrel_shifter #(.XLEN(64), .PIPE_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        zero;
        string       tag;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  shamt;
        logic [1:0]  op;
        logic [63:0] exp;
        string       name;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];
    exp_t cur_exp;
    logic rand_run = 1'b0;

    logic        prev_ok    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: plain SystemVerilog operators on the whole word.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int unsigned sh,
                                              input logic [1:0] op);
        logic [63:0] r;
        case (op)
            2'b00: r = d << sh;
            2'b01: r = d >> sh;
            2'b10: r = $signed(d) >>> sh;
`ifdef SHIFTER_ROTATE_EN
            default: r = (d >> sh) | (d << (64 - sh));
`else
            default: r = d >> sh;
`endif
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op,
                                input logic [63:0] e, input string name);
        vec_t v;
        v.data = d; v.shamt = sh; v.op = op; v.exp = e; v.name = name;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: record accepts, check results, holds and bubbles.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", out_data, prev_data);
            end
            if (prev_ok && !out_valid) chk("bubble_data", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.tag, "_data"}, out_data, e.data);
                    chk({e.tag, "_zero"}, 64'(out_zero), 64'(e.zero));
                    pop_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            prev_ok    = 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic drive(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op,
                         input logic [63:0] e, input string tag);
        in_valid     = 1'b1;
        in_data      = d;
        in_shamt     = sh;
        in_op        = op;
        cur_exp.data = e;
        cur_exp.zero = (e == 64'd0);
        cur_exp.tag  = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op,
                        input logic [63:0] e, input string tag);
        int   n = 0;
        logic acc = 1'b0;
        drive(d, sh, op, e, tag);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL %s_accept_timeout: got in_ready=0 want 1", tag);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_single(input vec_t v);
        int lat = 1;
        out_ready = 1'b1;
        send(v.data, v.shamt, v.op, v.exp, v.name);
        idle();
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, 64'(lat), 64'(2));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        logic [63:0] ror4, ror63, ror1;
`ifdef SHIFTER_ROTATE_EN
        ror4  = 64'h1000_0000_0000_0000;
        ror63 = 64'h0000_0000_0000_0003;
        ror1  = 64'h8000_0000_0000_0000;
`else
        ror4  = 64'h0;
        ror63 = 64'h0000_0000_0000_0001;
        ror1  = 64'h0;
`endif
        vecs[0]  = mk(64'h8000_0000_0000_0000, 6'd13, OP_SRL, 64'h0004_0000_0000_0000, "srl13");
        vecs[1]  = mk(64'h8000_0000_0000_0000, 6'd4,  OP_SRA, 64'hF800_0000_0000_0000, "sra4");
        vecs[2]  = mk(64'h0000_0000_0000_0001, 6'd63, OP_SLL, 64'h8000_0000_0000_0000, "sll63");
        vecs[3]  = mk(64'h0000_0000_0000_0001, 6'd4,  OP_ROR, ror4,                    "ror4");
        vecs[4]  = mk(64'hDEAD_BEEF_0123_4567, 6'd0,  OP_SLL, 64'hDEAD_BEEF_0123_4567, "id_sll");
        vecs[5]  = mk(64'hDEAD_BEEF_0123_4567, 6'd0,  OP_SRL, 64'hDEAD_BEEF_0123_4567, "id_srl");
        vecs[6]  = mk(64'hDEAD_BEEF_0123_4567, 6'd0,  OP_SRA, 64'hDEAD_BEEF_0123_4567, "id_sra");
        vecs[7]  = mk(64'hDEAD_BEEF_0123_4567, 6'd0,  OP_ROR, 64'hDEAD_BEEF_0123_4567, "id_ror");
        vecs[8]  = mk(64'h8000_0000_0000_0001, 6'd63, OP_ROR, ror63,                   "ror63");
        vecs[9]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, OP_SRL, 64'h0000_0000_0000_0001, "srl63");
        vecs[10] = mk(64'h8000_0000_0000_0000, 6'd63, OP_SRA, 64'hFFFF_FFFF_FFFF_FFFF, "sra63_neg");
        vecs[11] = mk(64'h7FFF_FFFF_FFFF_FFFF, 6'd63, OP_SRA, 64'h0,                   "sra63_pos");
        vecs[12] = mk(64'h0000_0000_0000_0001, 6'd1,  OP_ROR, ror1,                    "ror1");
        vecs[13] = mk(64'h0123_4567_89AB_CDEF, 6'd8,  OP_SLL, 64'h2345_6789_ABCD_EF00, "sll8");

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0;
        out_ready = 1'b1;
        cur_exp.data = '0; cur_exp.zero = 1'b1; cur_exp.tag = "none";

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_zero", 64'(out_zero), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 14; i++) run_single(vecs[i]);

        // Back-to-back SRL 0/4/32 -> results on consecutive cycles
        pop_cyc.delete();
        out_ready = 1'b1;
        send(64'hA0A0_A0A0_A0A0_A0A0, 6'd0,  OP_SRL, 64'hA0A0_A0A0_A0A0_A0A0, "b2b0");
        send(64'hA0A0_A0A0_A0A0_A0A0, 6'd4,  OP_SRL, 64'h0A0A_0A0A_0A0A_0A0A, "b2b4");
        send(64'hA0A0_A0A0_A0A0_A0A0, 6'd32, OP_SRL, 64'h0000_0000_A0A0_A0A0, "b2b32");
        idle();
        drain("b2b");
        chk("b2b_count", 64'(pop_cyc.size()), 64'(3));
        if (pop_cyc.size() == 3) begin
            chk("b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'(1));
            chk("b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'(1));
        end

        // Stall: consumer blocks for 3 cycles with the pipe full and a third op waiting
        pop_cyc.delete();
        out_ready = 1'b0;
        send(64'h0000_0000_0000_00F0, 6'd4, OP_SRL, 64'h0000_0000_0000_000F, "stallA");
        send(64'h0000_0000_0000_0001, 6'd2, OP_SLL, 64'h0000_0000_0000_0004, "stallB");
        drive(64'hF000_0000_0000_0000, 6'd8, OP_SRA, 64'hFFF0_0000_0000_0000, "stallC");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_out_data", out_data, 64'h0000_0000_0000_000F);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        idle();
        drain("stall");
        chk("stall_count", 64'(pop_cyc.size()), 64'(3));

        // Reset with two ops in flight
        out_ready = 1'b1;
        send(64'h1111_2222_3333_4444, 6'd4, OP_SRL, 64'h0111_1222_2333_3444, "rstA");
        send(64'h1111_2222_3333_4444, 6'd8, OP_SRL, 64'h0011_1122_2233_3344, "rstB");
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data", out_data, 64'h0);
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        run_single(mk(64'h0000_0000_0000_0100, 6'd8, OP_SRL, 64'h1, "after_rst"));

        // Random traffic with random back-pressure
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [63:0] d;
                    logic [5:0]  sh;
                    logic [1:0]  op;
                    d  = {$urandom(), $urandom()};
                    sh = 6'($urandom_range(0, 63));
                    op = 2'($urandom_range(0, 3));
                    if (i % 7 == 0) sh = 6'd63;
                    if (i % 11 == 0) sh = 6'd0;
                    send(d, sh, op, ref_shift(d, 32'(sh), op), "rand");
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                idle();
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
